serial_adder_ctrl: RTL and testbench

//   Bit-serial N-bit adder controller: time-shares one full-adder cell (two half_adder

---
 rtl/serial_adder_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell (two half adders + OR) reused for every bit.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             p, g0, g1, sum_bit, carry_next;
    logic [WIDTH:0]   sum_ext;

    half_adder u_ha0 (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .s_o (p),
        .c_o (g0)
    );

    half_adder u_ha1 (
        .a_i (p),
        .b_i (carry_q),
        .s_o (sum_bit),
        .c_o (g1)
    );

    assign carry_next = g0 | g1;
    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lines up with the LSB.
    assign sum_ext    = {sum_bit, sum_sr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        s_d      = s_q;
        cout_d   = cout_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = sum_ext[WIDTH:1];
                carry_d  = carry_next;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    s_d     = sum_ext[WIDTH:1];
                    cout_d  = carry_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: WIDTH=8 and WIDTH=1 instances checked against an a+b reference
// model with cycle-exact done/busy windows derived from the accept edge.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy8, done8, cout8, busy1, done1, cout1;
    logic [7:0] s8;
    logic [0:0] s1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc8 = 0;

    typedef struct {
        int res;
        int dcyc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    int next_acc[2]  = '{0, 0};
    int busy_lo[2]   = '{0, 0};
    int busy_hi[2]   = '{-1, -1};
    int last_res[2]  = '{0, 0};

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Decide, at the abstract level, whether the coming edge accepts a start.
    task automatic tick();
        int e;
        e = cyc + 1;
        if (rst_n && start8 && e >= next_acc[0]) begin
            q8.push_back('{int'(a8) + int'(b8), e + 8});
            busy_lo[0]  = e;
            busy_hi[0]  = e + 8;
            next_acc[0] = e + 10;
            acc8++;
        end
        if (rst_n && start1 && e >= next_acc[1]) begin
            q1.push_back('{int'(a1) + int'(b1), e + 1});
            busy_lo[1]  = e;
            busy_hi[1]  = e + 1;
            next_acc[1] = e + 3;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        q8.delete();
        q1.delete();
        next_acc = '{0, 0};
        busy_hi  = '{-1, -1};
        last_res = '{0, 0};
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input int gap);
        a8 = x; b8 = y; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (gap) tick();
    endtask

    always @(negedge clk) begin
        chk("busy8", int'(busy8), int'(cyc >= busy_lo[0] && cyc <= busy_hi[0]));
        if (q8.size() > 0 && q8[0].dcyc == cyc) begin
            chk("done8_pulse", int'(done8), 1);
            chk("sum8", int'({cout8, s8}), q8[0].res);
            last_res[0] = q8[0].res;
            void'(q8.pop_front());
        end else begin
            chk("done8_idle", int'(done8), 0);
            chk("hold8", int'({cout8, s8}), last_res[0]);
        end
        chk("busy1", int'(busy1), int'(cyc >= busy_lo[1] && cyc <= busy_hi[1]));
        if (q1.size() > 0 && q1[0].dcyc == cyc) begin
            chk("done1_pulse", int'(done1), 1);
            chk("sum1", int'({cout1, s1}), q1[0].res);
            last_res[1] = q1[0].res;
            void'(q1.pop_front());
        end else begin
            chk("done1_idle", int'(done1), 0);
            chk("hold1", int'({cout1, s1}), last_res[1]);
        end
    end

    initial begin
        int budget;
        #1;
        do_reset(3);

        // Directed sums, including WIDTH=1 carry case alongside the first op.
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        tick();
        start1 = 1'b0; start8 = 1'b0;
        repeat (11) tick();
        op8(8'hFF, 8'h01, 11);
        op8(8'hFF, 8'hFF, 11);

        // Starts during RUN and DONE must be ignored.
        op8(8'h10, 8'h20, 0);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        repeat (8) tick();
        start8 = 1'b0;
        repeat (4) tick();

        // Start held high back to back.
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        repeat (35) tick();
        start8 = 1'b0;
        repeat (12) tick();

        // Abandon an operation with reset in the middle of RUN.
        op8(8'h10, 8'h20, 11);
        op8(8'hF0, 8'h0F, 4);
        do_reset(2);
        op8(8'hF0, 8'h0F, 11);

        // Random sweep on both widths.
        budget = 30000;
        acc8 = 0;
        while (acc8 < 1000 && budget > 0) begin
            start8 = ($urandom_range(3) != 0);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            start1 = $urandom_range(1);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            tick();
            budget--;
        end
        chk("sweep_budget", int'(acc8 >= 1000), 1);
        start8 = 1'b0; start1 = 1'b0;
        repeat (14) tick();
        chk("drain8", q8.size(), 0);
        chk("drain1", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
